// File: rtl/sensor_sampler_ctrl.sv
// sensor_sampler_ctrl: periodic sensor enable/settle/capture scheduler with valid/ready sample output
module sensor_sampler_ctrl #(
  parameter int DATA_W        = 8,
  parameter int PERIOD_W      = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DATA_W-1:0]   threshold,
  input  logic [DATA_W-1:0]   sensor_data,
  output logic                sensor_en,
  output logic [DATA_W-1:0]   sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                alarm,
  output logic                overrun,
  input  logic                overrun_clr,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, WARMUP, CAPTURE, PRESENT} state_t;
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PERIOD_W-1:0] timer;
  logic tick;
  assign tick = run && (period <= PERIOD_W'(1) || timer >= period - PERIOD_W'(1));
  assign sensor_en = state == WARMUP || state == CAPTURE;
  assign sample_valid = state == PRESENT;
  assign busy = state != IDLE;
  // period timer: free-runs while run is high, restarts on every tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer <= '0;
    else timer <= (!run || tick) ? '0 : timer + PERIOD_W'(1);
  // state and settle counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  // next-state: ticks only start a transaction from IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: if (tick) begin
        state_nxt = WARMUP;
        cnt_nxt = '0;
      end
      WARMUP: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(SETTLE_CYCLES - 1)) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = PRESENT;
      PRESENT: if (sample_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // sample and alarm are latched only at the end of CAPTURE and held until the next one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sample_data <= '0;
      alarm <= 1'b0;
    end else if (state == CAPTURE) begin
      sample_data <= sensor_data;
      alarm <= sensor_data >= threshold;
    end
  // sticky overrun: a dropped tick wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) overrun <= 1'b0;
    else if (tick && busy) overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
endmodule

// File: tb/tb_sensor_sampler_ctrl.sv
// tb_sensor_sampler_ctrl: directed self-checking bench for sensor_sampler_ctrl
module tb_sensor_sampler_ctrl;
  logic clk = 1'b0;
  logic rst_n, run, sample_ready, overrun_clr;
  logic [15:0] period;
  logic [7:0] threshold, sensor_data, sample_data;
  logic sensor_en, sample_valid, alarm, overrun, busy;
  int n_cmp = 0;
  int n_err = 0;

  sensor_sampler_ctrl #(.DATA_W(8), .PERIOD_W(16), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .period(period), .threshold(threshold),
    .sensor_data(sensor_data), .sensor_en(sensor_en), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .alarm(alarm),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " en"}, 32'(sensor_en), 0);
    chk({tag, " valid"}, 32'(sample_valid), 0);
    chk({tag, " data"}, 32'(sample_data), 0);
    chk({tag, " alarm"}, 32'(alarm), 0);
    chk({tag, " overrun"}, 32'(overrun), 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; period = 16'd10; threshold = 8'h80;
    sensor_data = 8'h5A; sample_ready = 1'b1; overrun_clr = 1'b0;
    #3;
    chk_zero("reset");
    step(2);
    rst_n = 1'b1;
    // 1: period 10, capture 5A below threshold
    run = 1'b1;
    step(9);
    chk("t1 no tick before period", 32'(busy), 0);
    step(1);
    chk("t1 en after tick", 32'(sensor_en), 1);
    step(2);
    chk("t1 en in capture", 32'(sensor_en), 1);
    step(1);
    chk("t1 en off in present", 32'(sensor_en), 0);
    chk("t1 valid", 32'(sample_valid), 1);
    chk("t1 data", 32'(sample_data), 32'h5A);
    chk("t1 alarm", 32'(alarm), 0);
    step(1);
    chk("t1 valid one cycle", 32'(sample_valid), 0);
    chk("t1 idle", 32'(busy), 0);
    step(5);
    chk("t1 idle before 2nd tick", 32'(busy), 0);
    step(1);
    chk("t1 2nd tick en", 32'(sensor_en), 1);
    // 2: equal to threshold raises alarm, 7F clears it
    sensor_data = 8'h80;
    step(3);
    chk("t2 valid", 32'(sample_valid), 1);
    chk("t2 data", 32'(sample_data), 32'h80);
    chk("t2 alarm eq", 32'(alarm), 1);
    step(1);
    chk("t2 valid dropped", 32'(sample_valid), 0);
    chk("t2 alarm held", 32'(alarm), 1);
    sensor_data = 8'h7F;
    step(6);
    chk("t2 3rd tick en", 32'(sensor_en), 1);
    step(3);
    chk("t2 data 7F", 32'(sample_data), 32'h7F);
    chk("t2 alarm cleared", 32'(alarm), 0);
    // 3: stall with ready low, ticks dropped, threshold change ignored
    sample_ready = 1'b0; period = 16'd4; threshold = 8'h00; sensor_data = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t3 valid stable", 32'(sample_valid), 1);
      chk("t3 data stable", 32'(sample_data), 32'h7F);
    end
    chk("t3 overrun", 32'(overrun), 1);
    chk("t3 alarm unaffected", 32'(alarm), 0);
    run = 1'b0; sample_ready = 1'b1;
    step(1);
    chk("t3 released", 32'(sample_valid), 0);
    chk("t3 overrun sticky", 32'(overrun), 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    chk("t3 overrun cleared", 32'(overrun), 0);
    // 4: period 0 back-to-back transactions
    period = 16'd0; threshold = 8'h80; sensor_data = 8'h11; run = 1'b1;
    step(4);
    chk("t4 valid 1st", 32'(sample_valid), 1);
    chk("t4 data", 32'(sample_data), 32'h11);
    step(1);
    chk("t4 valid low", 32'(sample_valid), 0);
    chk("t4 overrun", 32'(overrun), 1);
    step(3);
    chk("t4 no valid mid", 32'(sample_valid), 0);
    step(1);
    chk("t4 valid 2nd", 32'(sample_valid), 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    chk("t4 set wins over clr", 32'(overrun), 1);
    step(1);
    chk("t4 3rd warmup", 32'(sensor_en), 1);
    // 5: run drops during warmup, sample still delivered
    run = 1'b0; sensor_data = 8'h22;
    step(3);
    chk("t5 valid", 32'(sample_valid), 1);
    chk("t5 data", 32'(sample_data), 32'h22);
    step(1);
    chk("t5 idle", 32'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t5 no en", 32'(sensor_en), 0);
    end
    // 6: async reset while presenting
    period = 16'd6; sensor_data = 8'h9C; sample_ready = 1'b0; run = 1'b1;
    step(9);
    chk("t6 valid", 32'(sample_valid), 1);
    chk("t6 data", 32'(sample_data), 32'h9C);
    chk("t6 alarm", 32'(alarm), 1);
    step(3);
    chk("t6 overrun", 32'(overrun), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("t6 async reset");
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("t6 no early tick", 32'(busy), 0);
    step(1);
    chk("t6 tick after period", 32'(sensor_en), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
